// File: rtl/prbs15_checker_if.sv
// Byte-link bundle between the PRBS-15 source side and the checker.
// The master drives the stream and controls; the slave reports link status.
interface prbs15_checker_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic [7:0]       data_in;
    logic             data_valid;
    logic             clr_cnt;
    logic             locked;
    logic             byte_err;
    logic [CNT_W-1:0] err_count;

    modport master (
        output enable, data_in, data_valid, clr_cnt,
        input  locked, byte_err, err_count
    );

    modport slave (
        input  enable, data_in, data_valid, clr_cnt,
        output locked, byte_err, err_count
    );
endinterface

// File: rtl/prbs15_checker.sv
// Self-synchronising PRBS-15 (x^15 + x^14 + 1) byte checker with lock tracking
// and a saturating bit-error counter.
//
// state  | meaning
// IDLE   | disarmed, waiting for enable
// SEED0  | loading first received byte into the history
// SEED1  | loading second received byte into the history
// ACQ    | counting consecutive correctly predicted bytes
// LOCKED | tracking the stream, counting bit errors
module prbs15_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    prbs15_checker_if.slave  bus
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);

    typedef enum logic [2:0] {IDLE, SEED0, SEED1, ACQ, LOCKED} state_t;

    state_t           state, state_n;
    logic [14:0]      hist, hist_n;
    logic [14:0]      h_pred, h_rx;
    logic [7:0]       pred, diff;
    logic [3:0]       pop, add_n;
    logic [GW-1:0]    good_run, good_n;
    logic [BW-1:0]    bad_run, bad_n;
    logic             berr_n, byte_err;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W:0]   sum;

    // hist[0] is the newest bit; the next bit is hist[13] ^ hist[14].
    always_comb begin
        h_pred = hist;
        h_rx   = hist;
        pred   = '0;
        for (int i = 0; i < 8; i++) begin
            pred[i] = h_pred[13] ^ h_pred[14];
            h_pred  = {h_pred[13:0], pred[i]};
            h_rx    = {h_rx[13:0], bus.data_in[i]};
        end
        diff = bus.data_in ^ pred;
        pop  = '0;
        for (int i = 0; i < 8; i++) begin
            pop = pop + 4'(diff[i]);
        end
    end

    always_comb begin
        state_n = state;
        hist_n  = hist;
        good_n  = good_run;
        bad_n   = bad_run;
        berr_n  = 1'b0;
        add_n   = '0;
        if (!bus.enable) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: state_n = SEED0;
                SEED0: if (bus.data_valid) begin
                    hist_n  = h_rx;
                    state_n = SEED1;
                end
                SEED1: if (bus.data_valid) begin
                    hist_n  = h_rx;
                    good_n  = '0;
                    state_n = ACQ;
                end
                ACQ: if (bus.data_valid) begin
                    hist_n = h_pred;
                    if (diff == '0) begin
                        if (good_run == GW'(LOCK_CNT - 1)) begin
                            state_n = LOCKED;
                            bad_n   = '0;
                        end else begin
                            good_n = good_run + 1'b1;
                        end
                    end else begin
                        state_n = SEED0;
                    end
                end
                LOCKED: if (bus.data_valid) begin
                    // History follows the prediction so a corrupted byte cannot
                    // poison later predictions.
                    hist_n = h_pred;
                    add_n  = pop;
                    if (diff != '0) begin
                        berr_n = 1'b1;
                        if (bad_run == BW'(LOSS_CNT - 1)) begin
                            state_n = SEED0;
                        end else begin
                            bad_n = bad_run + 1'b1;
                        end
                    end else begin
                        bad_n = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hist     <= '0;
            good_run <= '0;
            bad_run  <= '0;
            byte_err <= 1'b0;
        end else begin
            state    <= state_n;
            hist     <= hist_n;
            good_run <= good_n;
            bad_run  <= bad_n;
            byte_err <= berr_n;
        end
    end

    assign sum = {1'b0, err_count} + {{(CNT_W - 3){1'b0}}, add_n};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (bus.clr_cnt) begin
            err_count <= '0;
        end else if (sum[CNT_W]) begin
            err_count <= '1;
        end else begin
            err_count <= sum[CNT_W-1:0];
        end
    end

    assign bus.locked    = (state == LOCKED);
    assign bus.byte_err  = byte_err;
    assign bus.err_count = err_count;
endmodule

// File: tb/tb_prbs15_checker.sv
// Randomised scoreboard bench for prbs15_checker against a bit-level model
// built directly from the stream recurrence b[k] = b[k-14] ^ b[k-15].
module tb_prbs15_checker;
    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 4;
    localparam int CNT_W    = 8;
    localparam int CMAX     = (1 << CNT_W) - 1;

    localparam int M_IDLE   = 0;
    localparam int M_SEED0  = 1;
    localparam int M_SEED1  = 2;
    localparam int M_ACQ    = 3;
    localparam int M_LOCKED = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prbs15_checker_if #(.CNT_W(CNT_W)) intf ();

    prbs15_checker #(
        .LOCK_CNT(LOCK_CNT),
        .LOSS_CNT(LOSS_CNT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(intf.master)
    );

    int compared   = 0;
    int mismatched = 0;
    logic [CNT_W+1:0] exp_q[$];

    // ---------------- stream generator ----------------
    logic [14:0] g_seed;
    int          g_emitted;
    bit          g_hist[$];

    task automatic restart_stream(input logic [14:0] seed);
        g_seed    = seed;
        g_emitted = 0;
        g_hist.delete();
    endtask

    function automatic bit next_bit();
        bit b;
        if (g_emitted < 15) b = g_seed[g_emitted];
        else b = g_hist[g_hist.size()-14] ^ g_hist[g_hist.size()-15];
        g_hist.push_back(b);
        if (g_hist.size() > 15) void'(g_hist.pop_front());
        g_emitted++;
        return b;
    endfunction

    function automatic logic [7:0] next_byte();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = next_bit();
        return v;
    endfunction

    // ---------------- reference model ----------------
    int m_mode, m_good, m_bad, m_cnt;
    bit m_locked, m_berr;
    bit m_hist[$];

    task automatic model_reset();
        m_mode = M_IDLE; m_good = 0; m_bad = 0; m_cnt = 0;
        m_locked = 0; m_berr = 0;
        m_hist.delete();
        repeat (15) m_hist.push_back(1'b0);
    endtask

    task automatic model_push(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            m_hist.push_back(v[i]);
            void'(m_hist.pop_front());
        end
    endtask

    function automatic logic [7:0] model_predict();
        bit b[23];
        logic [7:0] p;
        for (int i = 0; i < 15; i++) b[i] = m_hist[i];
        for (int i = 0; i < 8; i++) b[15+i] = b[1+i] ^ b[i];
        for (int i = 0; i < 8; i++) p[i] = b[15+i];
        return p;
    endfunction

    task automatic model_step(input bit en, input bit dv, input logic [7:0] d, input bit clr);
        logic [7:0] p;
        int add;
        add = 0;
        m_berr = 0;
        if (!en) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_SEED0;
        end else if (dv) begin
            if (m_mode == M_SEED0) begin
                model_push(d); m_mode = M_SEED1;
            end else if (m_mode == M_SEED1) begin
                model_push(d); m_mode = M_ACQ; m_good = 0;
            end else if (m_mode == M_ACQ) begin
                p = model_predict();
                model_push(p);
                if (d == p) begin
                    m_good++;
                    if (m_good == LOCK_CNT) begin m_mode = M_LOCKED; m_bad = 0; end
                end else begin
                    m_mode = M_SEED0;
                end
            end else begin
                p = model_predict();
                model_push(p);
                add = $countones(d ^ p);
                if (add != 0) begin
                    m_berr = 1;
                    m_bad++;
                    if (m_bad == LOSS_CNT) m_mode = M_SEED0;
                end else begin
                    m_bad = 0;
                end
            end
        end
        if (clr) m_cnt = 0;
        else m_cnt = (m_cnt + add > CMAX) ? CMAX : m_cnt + add;
        m_locked = (m_mode == M_LOCKED);
    endtask

    // ---------------- stimulus ----------------
    task automatic cyc(input bit en, input bit dv, input logic [7:0] emask, input bit clr);
        logic [7:0] d;
        @(negedge clk);
        d = dv ? (next_byte() ^ emask) : 8'($urandom);
        rst             = 1'b0;
        intf.enable     = en;
        intf.data_valid = dv;
        intf.data_in    = d;
        intf.clr_cnt    = clr;
        model_step(en, dv, d, clr);
        exp_q.push_back({m_locked, m_berr, CNT_W'(m_cnt)});
    endtask

    task automatic rst_cyc();
        @(negedge clk);
        rst             = 1'b1;
        intf.enable     = 1'b0;
        intf.data_valid = 1'b0;
        intf.clr_cnt    = 1'b0;
        model_reset();
        exp_q.push_back({1'b0, 1'b0, CNT_W'(0)});
        #1;
        compared++;
        if (intf.locked !== 1'b0 || intf.err_count !== '0) begin
            mismatched++;
            $display("FAIL async_rst: locked=%b err_count=%0d, required locked=0 err_count=0",
                     intf.locked, intf.err_count);
        end
    endtask

    task automatic direct_check(input string name, input bit lk, input int cnt);
        compared++;
        if (intf.locked !== lk || intf.err_count !== CNT_W'(cnt)) begin
            mismatched++;
            $display("FAIL %s: locked=%b err_count=%0d, required locked=%b err_count=%0d",
                     name, intf.locked, intf.err_count, lk, cnt);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [CNT_W+1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                compared++;
                if ({intf.locked, intf.byte_err, intf.err_count} !== e) begin
                    mismatched++;
                    $display("FAIL outputs @%0t: locked=%b byte_err=%b err_count=%0d, required locked=%b byte_err=%b err_count=%0d",
                             $time, intf.locked, intf.byte_err, intf.err_count,
                             e[CNT_W+1], e[CNT_W], e[CNT_W-1:0]);
                end
            end
        end
    end

    initial begin : stimulus
        intf.enable = 1'b0; intf.data_valid = 1'b0; intf.data_in = '0; intf.clr_cnt = 1'b0;
        model_reset();
        repeat (2) rst_cyc();

        // Known seed 7FFF; the first enabled cycle carries no data.
        restart_stream(15'h7FFF);
        cyc(1, 0, 8'h00, 0);
        repeat (2 + LOCK_CNT) cyc(1, 1, 8'h00, 0);
        @(posedge clk); #1;
        direct_check("lock_latency", 1'b1, 0);

        repeat (5) cyc(1, 1, 8'h00, 0);
        cyc(1, 1, 8'h08, 0);
        repeat (3) cyc(1, 1, 8'h00, 0);
        cyc(1, 1, 8'hFF, 0);
        repeat (3) cyc(1, 1, 8'h00, 0);
        @(posedge clk); #1;
        direct_check("single_and_byte_errors", 1'b1, 9);

        // Loss of lock followed by reseed and relock.
        repeat (LOSS_CNT) cyc(1, 1, 8'hFF, 0);
        repeat (3) cyc(1, 1, 8'h00, 0);
        repeat (10) cyc(1, 1, 8'h00, 0);
        @(posedge clk); #1;
        direct_check("relock_after_loss", 1'b1, 41);

        // Sparse valid: one of three cycles.
        rst_cyc();
        restart_stream(15'($urandom_range(1, 32767)));
        for (int i = 0; i < 40; i++) cyc(1, (i % 3) == 0, 8'h00, 0);

        // Saturation: three errored bytes then a clean one keeps lock.
        for (int i = 0; i < 15; i++) begin
            repeat (3) cyc(1, 1, 8'($urandom_range(1, 255)), 0);
            cyc(1, 1, 8'h00, 0);
        end
        cyc(1, 1, 8'hFF, 1);
        cyc(1, 1, 8'h00, 0);

        // enable drop while locked, then async reset while locked.
        repeat (2) cyc(1, 1, 8'h10, 0);
        cyc(0, 1, 8'h00, 0);
        repeat (10) cyc(1, 1, 8'h00, 0);
        cyc(1, 1, 8'h01, 0);
        rst_cyc();
        repeat (10) cyc(1, 1, 8'h00, 0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            bit en, dv, clr;
            logic [7:0] em;
            en  = ($urandom_range(0, 299) != 0);
            dv  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 15))
                0:       em = 8'($urandom_range(1, 255));
                1:       em = 8'h01 << $urandom_range(0, 7);
                default: em = 8'h00;
            endcase
            if ($urandom_range(0, 499) == 0) begin
                rst_cyc();
            end else if ($urandom_range(0, 299) == 0) begin
                repeat (LOSS_CNT) cyc(1, 1, 8'hFF, 0);
            end else begin
                cyc(en, dv, em, clr);
            end
        end

        @(posedge clk); #2;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
